command_encoder: RTL and testbench
==================================

COMMAND_ENCODER -- requirements
Module: command_encoder

Interface
REQ-001 Parameter N_BLOCKS, default 32, number of addressable blocks; block byte carries the low clog2(N_BLOCKS) bits.
REQ-002 Parameter REG_ADDR_WIDTH, default 4, block register address width.
REQ-003 Parameter DATA_WIDTH, default 16, data field width (multiple of 8).
REQ-004 Parameter INSTR_WIDTH, default 32, block instruction width (multiple of 8).
REQ-005 Parameter GAP_CYCLES, default 1, minimum idle cycles with out_valid low between consecutive bytes (0 allowed).
REQ-006 clk  in  1  sole clock; all logic is on the rising edge.
REQ-007 reset  in  1  asynchronous, active-low reset.
REQ-008 cmd_valid  in  1  command request; cmd_ready  out  1  encoder idle and accepting.
REQ-009 cmd_opcode  in  8  command byte; cmd_fmt  in  3  frame format (0 OP, 1 BLK_INSTR, 2 BLK_REG_DATA, 3 DATA, 4 DATA_DELAY, 5-7 illegal).
REQ-010 cmd_block  in  clog2(N_BLOCKS); cmd_reg  in  REG_ADDR_WIDTH; cmd_data  in  DATA_WIDTH; cmd_instr  in  INSTR_WIDTH; cmd_delay  in  2*DATA_WIDTH: frame fields.
REQ-011 out_byte  out  8  byte to controller; out_valid  out  1  byte present; out_ack  in  1  controller consumed byte.
REQ-012 abort  in  1  synchronous frame abort; cmd_done  out  1  one-cycle pulse, frame fully sent; cmd_reject  out  1  one-cycle pulse, illegal cmd_fmt.

Function
REQ-013 States SHALL be IDLE, OPCODE, BLOCK, REG, DATA, INSTR, DELAY, GAP; cmd_ready SHALL be 1 exactly in IDLE.
REQ-014 Accept when cmd_valid && cmd_ready && !abort with legal cmd_fmt: all fields latched that edge, next state OPCODE; input changes afterwards SHALL not affect the frame.
REQ-015 Illegal cmd_fmt on a would-be accept: cmd_reject pulses next cycle, no byte emitted, state stays IDLE.
REQ-016 Frame byte order: OP = opcode; BLK_INSTR = opcode, block, instr; BLK_REG_DATA = opcode, block, reg, data; DATA = opcode, data; DATA_DELAY = opcode, data, delay.
REQ-017 Block and reg bytes SHALL be zero-extended to 8 bits; data is DATA_WIDTH/8 bytes, instr INSTR_WIDTH/8 bytes, delay 2*DATA_WIDTH/8 bytes, each MSB-first.
REQ-018 First byte (opcode) SHALL have out_valid high on the cycle after acceptance.
REQ-019 out_byte SHALL be held stable while out_valid is high; a byte is consumed on an edge where out_valid && out_ack.
REQ-020 After consumption out_valid SHALL drop next cycle and stay low exactly GAP_CYCLES cycles (GAP state) before the next byte; with GAP_CYCLES=0 the next byte is presented on the cycle after consumption.
REQ-021 out_ack while out_valid low SHALL be ignored.
REQ-022 Intra-field byte counter SHALL reset to 0 at each field start; a field ends when counter reaches bytes-per-field minus 1 at consumption.
REQ-023 On consumption of the last frame byte, cmd_done pulses the next cycle, state returns to IDLE that cycle (no trailing gap); a new command may be accepted that same cycle.
REQ-024 abort high in any non-IDLE state: next cycle state IDLE, out_valid 0, counters cleared, no cmd_done; abort simultaneous with out_ack still discards the frame.
REQ-025 abort in IDLE SHALL block acceptance that cycle and otherwise have no effect.

Reset
REQ-026 reset low SHALL immediately force IDLE, out_valid 0, out_byte 0x00, cmd_done 0, cmd_reject 0, counters 0, latched fields 0; cmd_ready 1 after release.
REQ-027 reset asserted mid-frame SHALL drop the frame without cmd_done; first accept possible on the first rising edge after release.

Verification
REQ-028 OP frame, opcode 0x05, out_ack tied high, GAP_CYCLES=1 -> single byte 0x05, cmd_done one cycle after its consumption, cmd_ready high again.
REQ-029 BLK_REG_DATA opcode 0x02, block 3, reg 0xA, data 0xBEEF -> bytes 0x02,0x03,0x0A,0xBE,0xEF, each separated by exactly 1 low out_valid cycle.
REQ-030 DATA_DELAY opcode 0x04, data 0x1234, delay 0x00012C00, out_ack delayed 3 cycles per byte -> bytes 0x04,0x12,0x34,0x00,0x01,0x2C,0x00, out_byte stable while waiting.
REQ-031 BLK_INSTR with INSTR_WIDTH=32, block 31, instr 0xDEADBEEF, GAP_CYCLES=0 -> 0xXX,0x1F,0xDE,0xAD,0xBE,0xEF back-to-back on continuous ack.
REQ-032 cmd_fmt=6 -> cmd_reject pulse, no out_valid; then abort after 2 bytes of a BLK_REG_DATA frame -> out_valid 0 next cycle, no cmd_done, next command sends from opcode.
REQ-033 reset low during DATA byte of a DATA frame -> out_valid 0 immediately, no cmd_done; after release a new OP frame completes normally.

Source files
------------

// File: rtl/command_encoder.sv
// command_encoder: serialises command frames into a byte stream
// with a valid/ack handshake and a fixed idle gap between bytes.
module command_encoder #(
    parameter int N_BLOCKS       = 32,
    parameter int REG_ADDR_WIDTH = 4,
    parameter int DATA_WIDTH     = 16,
    parameter int INSTR_WIDTH    = 32,
    parameter int GAP_CYCLES     = 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          cmd_valid,
    output logic                          cmd_ready,
    input  logic [7:0]                    cmd_opcode,
    input  logic [2:0]                    cmd_fmt,
    input  logic [$clog2(N_BLOCKS)-1:0]   cmd_block,
    input  logic [REG_ADDR_WIDTH-1:0]     cmd_reg,
    input  logic [DATA_WIDTH-1:0]         cmd_data,
    input  logic [INSTR_WIDTH-1:0]        cmd_instr,
    input  logic [2*DATA_WIDTH-1:0]       cmd_delay,
    output logic [7:0]                    out_byte,
    output logic                          out_valid,
    input  logic                          out_ack,
    input  logic                          abort,
    output logic                          cmd_done,
    output logic                          cmd_reject
);

    localparam int BW = $clog2(N_BLOCKS);
    localparam int DB = DATA_WIDTH / 8;
    localparam int IB = INSTR_WIDTH / 8;
    localparam int LB = 2 * DB;

    localparam logic [2:0] F_OP  = 3'd0;
    localparam logic [2:0] F_BI  = 3'd1;
    localparam logic [2:0] F_BRD = 3'd2;
    localparam logic [2:0] F_D   = 3'd3;
    localparam logic [2:0] F_DD  = 3'd4;

    typedef enum logic [2:0] {
        IDLE, OPCODE, BLOCK, REG, DATA, INSTR, DELAY, GAP
    } state_t;

    state_t state_q, state_d;
    state_t resume_q, resume_d;
    state_t nxt_field, target;

    logic [7:0] cnt_q, cnt_d;
    logic [7:0] gap_q, gap_d;
    logic [7:0] last_idx;
    logic       done_q, done_d;
    logic       rej_q, rej_d;
    logic       legal, accept, last;

    logic [2:0]                fmt_q;
    logic [7:0]                op_q;
    logic [BW-1:0]             blk_q;
    logic [REG_ADDR_WIDTH-1:0] reg_q;
    logic [DATA_WIDTH-1:0]     data_q;
    logic [INSTR_WIDTH-1:0]    instr_q;
    logic [2*DATA_WIDTH-1:0]   delay_q;

    assign legal      = (cmd_fmt <= F_DD);
    assign cmd_ready  = (state_q == IDLE);
    assign accept     = cmd_valid && cmd_ready && !abort && legal;
    assign out_valid  = (state_q != IDLE) && (state_q != GAP);
    assign cmd_done   = done_q;
    assign cmd_reject = rej_q;
    assign last       = (cnt_q == last_idx);

    // Current byte, field length and the field that follows this one.
    always_comb begin
        out_byte  = 8'h00;
        last_idx  = 8'd0;
        nxt_field = IDLE;
        unique case (state_q)
            IDLE:   ;
            GAP:    ;
            OPCODE: begin
                out_byte = op_q;
                unique case (fmt_q)
                    F_BI, F_BRD: nxt_field = BLOCK;
                    F_D, F_DD:   nxt_field = DATA;
                    default:     nxt_field = IDLE;
                endcase
            end
            BLOCK: begin
                out_byte  = 8'(blk_q);
                nxt_field = (fmt_q == F_BI) ? INSTR : REG;
            end
            REG: begin
                out_byte  = 8'(reg_q);
                nxt_field = DATA;
            end
            DATA: begin
                out_byte  = data_q[8*(DB-1-int'(cnt_q)) +: 8];
                last_idx  = 8'(DB - 1);
                nxt_field = (fmt_q == F_DD) ? DELAY : IDLE;
            end
            INSTR: begin
                out_byte = instr_q[8*(IB-1-int'(cnt_q)) +: 8];
                last_idx = 8'(IB - 1);
            end
            DELAY: begin
                out_byte = delay_q[8*(LB-1-int'(cnt_q)) +: 8];
                last_idx = 8'(LB - 1);
            end
        endcase
    end

    // Next-state logic: accept/reject, byte handshake, gap timing, abort.
    always_comb begin
        state_d  = state_q;
        resume_d = resume_q;
        cnt_d    = cnt_q;
        gap_d    = gap_q;
        done_d   = 1'b0;
        rej_d    = 1'b0;
        target   = state_q;
        if (state_q == IDLE) begin
            if (cmd_valid && !abort) begin
                if (legal) begin
                    state_d = OPCODE;
                    cnt_d   = 8'd0;
                end else begin
                    rej_d = 1'b1;
                end
            end
        end else if (abort) begin
            state_d  = IDLE;
            resume_d = IDLE;
            cnt_d    = 8'd0;
            gap_d    = 8'd0;
        end else if (state_q == GAP) begin
            if (gap_q == 8'(GAP_CYCLES - 1)) begin
                state_d = resume_q;
                gap_d   = 8'd0;
            end else begin
                gap_d = gap_q + 8'd1;
            end
        end else if (out_ack) begin
            target = last ? nxt_field : state_q;
            cnt_d  = last ? 8'd0 : cnt_q + 8'd1;
            if (target == IDLE) begin
                state_d = IDLE;
                done_d  = 1'b1;
            end else if (GAP_CYCLES == 0) begin
                state_d = target;
            end else begin
                state_d  = GAP;
                resume_d = target;
                gap_d    = 8'd0;
            end
        end
    end

    // State, counters and status pulses.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            resume_q <= IDLE;
            cnt_q    <= 8'd0;
            gap_q    <= 8'd0;
            done_q   <= 1'b0;
            rej_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            resume_q <= resume_d;
            cnt_q    <= cnt_d;
            gap_q    <= gap_d;
            done_q   <= done_d;
            rej_q    <= rej_d;
        end
    end

    // Capture the whole command on acceptance so inputs may change freely.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fmt_q   <= '0;
            op_q    <= '0;
            blk_q   <= '0;
            reg_q   <= '0;
            data_q  <= '0;
            instr_q <= '0;
            delay_q <= '0;
        end else if (accept) begin
            fmt_q   <= cmd_fmt;
            op_q    <= cmd_opcode;
            blk_q   <= cmd_block;
            reg_q   <= cmd_reg;
            data_q  <= cmd_data;
            instr_q <= cmd_instr;
            delay_q <= cmd_delay;
        end
    end

endmodule

// File: tb/tb_command_encoder.sv
// tb_command_encoder: directed frames against two encoders,
// one with a one-cycle inter-byte gap and one with no gap.
module tb_command_encoder;

    logic        clk = 1'b0;
    logic        reset;
    logic        cv1, cv0;
    logic [7:0]  cmd_opcode;
    logic [2:0]  cmd_fmt;
    logic [4:0]  cmd_block;
    logic [3:0]  cmd_reg;
    logic [15:0] cmd_data;
    logic [31:0] cmd_instr;
    logic [31:0] cmd_delay;
    logic        ack, abort;

    logic       g1_ready, g1_valid, g1_done, g1_rej;
    logic [7:0] g1_byte;
    logic       g0_ready, g0_valid, g0_done, g0_rej;
    logic [7:0] g0_byte;

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0] got[32];
    int         gaps[32];
    int         nb;
    int         done_lat;
    bit         stable_ok;
    bit         fin;
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    command_encoder #(.GAP_CYCLES(1)) u_g1 (
        .clk(clk), .reset(reset),
        .cmd_valid(cv1), .cmd_ready(g1_ready),
        .cmd_opcode(cmd_opcode), .cmd_fmt(cmd_fmt),
        .cmd_block(cmd_block), .cmd_reg(cmd_reg),
        .cmd_data(cmd_data), .cmd_instr(cmd_instr),
        .cmd_delay(cmd_delay),
        .out_byte(g1_byte), .out_valid(g1_valid), .out_ack(ack),
        .abort(abort), .cmd_done(g1_done), .cmd_reject(g1_rej)
    );

    command_encoder #(.GAP_CYCLES(0)) u_g0 (
        .clk(clk), .reset(reset),
        .cmd_valid(cv0), .cmd_ready(g0_ready),
        .cmd_opcode(cmd_opcode), .cmd_fmt(cmd_fmt),
        .cmd_block(cmd_block), .cmd_reg(cmd_reg),
        .cmd_data(cmd_data), .cmd_instr(cmd_instr),
        .cmd_delay(cmd_delay),
        .out_byte(g0_byte), .out_valid(g0_valid), .out_ack(ack),
        .abort(abort), .cmd_done(g0_done), .cmd_reject(g0_rej)
    );

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one command and collect its bytes until cmd_done.
    task automatic send(input string tag, input bit use_g0,
                        input logic [2:0] fmt, input logic [7:0] op,
                        input logic [4:0] blk, input logic [3:0] rg,
                        input logic [15:0] d, input logic [31:0] ins,
                        input logic [31:0] dly, input int ack_dly,
                        input bit tied);
        int low, wc, since;
        logic [7:0] held, b;
        logic v;
        cmd_fmt = fmt; cmd_opcode = op; cmd_block = blk;
        cmd_reg = rg; cmd_data = d; cmd_instr = ins; cmd_delay = dly;
        ack = tied;
        check({tag, " ready"}, use_g0 ? g0_ready : g1_ready, 1);
        if (use_g0) cv0 = 1'b1;
        else cv1 = 1'b1;
        tick();
        cv0 = 1'b0; cv1 = 1'b0;
        cmd_fmt = 3'd0; cmd_opcode = 8'hFF; cmd_block = 5'h0A;
        cmd_reg = 4'h5; cmd_data = 16'h5A5A; cmd_instr = 32'h0;
        cmd_delay = 32'hFFFF_FFFF;
        nb = 0; low = 0; wc = 0; since = 0; done_lat = -1;
        stable_ok = 1'b1; fin = 1'b0; held = 8'h00;
        for (int c = 0; c < 300 && !fin; c++) begin
            v = use_g0 ? g0_valid : g1_valid;
            b = use_g0 ? g0_byte : g1_byte;
            since++;
            if (use_g0 ? g0_done : g1_done) begin
                done_lat = since;
                fin = 1'b1;
            end else if (v) begin
                if (wc == 0) begin
                    gaps[nb%32] = low;
                    low = 0;
                    held = b;
                end else if (b !== held) begin
                    stable_ok = 1'b0;
                end
                if (wc >= ack_dly) begin
                    ack = 1'b1;
                    got[nb%32] = b;
                    nb++;
                    wc = 0;
                    since = 0;
                end else begin
                    ack = 1'b0;
                    wc++;
                end
            end else begin
                low++;
                ack = tied;
            end
            if (!fin) tick();
        end
        ack = 1'b0;
        check({tag, " finished"}, fin, 1);
    endtask

    task automatic check_frame(input string tag, input int gap);
        check({tag, " nbytes"}, nb, exp_q.size());
        foreach (exp_q[i]) begin
            check($sformatf("%s byte%0d", tag, i), got[i], exp_q[i]);
            check($sformatf("%s gap%0d", tag, i), gaps[i], (i == 0) ? 0 : gap);
        end
        check({tag, " done_lat"}, done_lat, 1);
        check({tag, " stable"}, stable_ok, 1);
    endtask

    initial begin
        reset = 1'b0; cv1 = 1'b0; cv0 = 1'b0; ack = 1'b0; abort = 1'b0;
        cmd_opcode = 8'h00; cmd_fmt = 3'd0; cmd_block = 5'd0;
        cmd_reg = 4'd0; cmd_data = 16'd0; cmd_instr = 32'd0;
        cmd_delay = 32'd0;
        #3;
        check("rst valid", g1_valid, 0);
        check("rst byte", g1_byte, 8'h00);
        check("rst done", g1_done, 0);
        check("rst reject", g1_rej, 0);
        check("rst valid g0", g0_valid, 0);
        tick(); tick();
        reset = 1'b1;
        #1;
        check("rst ready", g1_ready, 1);

        // single-byte OP frame, ack tied high
        send("op", 0, 3'd0, 8'h05, 5'd0, 4'd0, 16'd0, 32'd0, 32'd0, 0, 1);
        exp_q = {8'h05};
        check_frame("op", 1);
        check("op ready after", g1_ready, 1);
        tick();
        check("op done pulse", g1_done, 0);

        // BLK_REG_DATA frame
        send("brd", 0, 3'd2, 8'h02, 5'd3, 4'hA, 16'hBEEF, 32'd0, 32'd0, 0, 1);
        exp_q = {8'h02, 8'h03, 8'h0A, 8'hBE, 8'hEF};
        check_frame("brd", 1);

        // DATA_DELAY frame, ack three cycles late on each byte
        send("dd", 0, 3'd4, 8'h04, 5'd0, 4'd0, 16'h1234, 32'd0,
             32'h0001_2C00, 3, 0);
        exp_q = {8'h04, 8'h12, 8'h34, 8'h00, 8'h01, 8'h2C, 8'h00};
        check_frame("dd", 1);

        // BLK_INSTR frame on the zero-gap encoder
        send("bi", 1, 3'd1, 8'h31, 5'd31, 4'd0, 16'd0, 32'hDEAD_BEEF,
             32'd0, 0, 1);
        exp_q = {8'h31, 8'h1F, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
        check_frame("bi", 0);
        tick();

        // illegal format
        cmd_fmt = 3'd6; cmd_opcode = 8'h66; cv1 = 1'b1;
        tick();
        cv1 = 1'b0;
        check("rej pulse", g1_rej, 1);
        check("rej valid", g1_valid, 0);
        check("rej ready", g1_ready, 1);
        tick();
        check("rej clear", g1_rej, 0);
        check("rej valid2", g1_valid, 0);

        // abort in IDLE blocks acceptance
        cmd_fmt = 3'd0; cmd_opcode = 8'h44; cv1 = 1'b1; abort = 1'b1;
        tick();
        cv1 = 1'b0; abort = 1'b0;
        check("idle abort ready", g1_ready, 1);
        check("idle abort valid", g1_valid, 0);

        // abort after two bytes of a BLK_REG_DATA frame
        cmd_fmt = 3'd2; cmd_opcode = 8'h22; cmd_block = 5'd5;
        cmd_reg = 4'd3; cmd_data = 16'h1111; cv1 = 1'b1; ack = 1'b1;
        tick();
        cv1 = 1'b0;
        check("ab byte0", g1_byte, 8'h22);
        check("ab valid0", g1_valid, 1);
        tick();
        check("ab gap0", g1_valid, 0);
        tick();
        check("ab byte1", g1_byte, 8'h05);
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0; ack = 1'b0;
        check("ab valid", g1_valid, 0);
        check("ab ready", g1_ready, 1);
        check("ab done", g1_done, 0);
        tick();
        check("ab done2", g1_done, 0);
        check("ab valid2", g1_valid, 0);
        send("post-ab", 0, 3'd0, 8'h07, 5'd0, 4'd0, 16'd0, 32'd0, 32'd0, 0, 1);
        exp_q = {8'h07};
        check_frame("post-ab", 1);

        // reset during the data byte of a DATA frame
        cmd_fmt = 3'd3; cmd_opcode = 8'h33; cmd_data = 16'hABCD;
        cv1 = 1'b1;
        tick();
        cv1 = 1'b0;
        check("rs byte0", g1_byte, 8'h33);
        ack = 1'b1;
        tick();
        ack = 1'b0;
        tick();
        check("rs data byte", g1_byte, 8'hAB);
        check("rs data valid", g1_valid, 1);
        #2;
        reset = 1'b0;
        #1;
        check("rs valid", g1_valid, 0);
        check("rs byte", g1_byte, 8'h00);
        check("rs ready", g1_ready, 1);
        tick();
        check("rs done", g1_done, 0);
        reset = 1'b1;
        send("post-rs", 0, 3'd0, 8'h09, 5'd0, 4'd0, 16'd0, 32'd0, 32'd0, 0, 1);
        exp_q = {8'h09};
        check_frame("post-rs", 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
